// File: rtl/lfsr_ctrl_pkg.sv
// Shared constants for the LFSR run controller.
// Contents: register offsets inside the bus window, CTRL and STATUS
// bit positions, and the run FSM state encoding.
package lfsr_ctrl_pkg;

  // Byte offsets from BASE_ADDR
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_SEED   = 32'h08;
  localparam logic [31:0] OFF_COUNT  = 32'h0C;
  localparam logic [31:0] OFF_DATA   = 32'h10;
  localparam logic [31:0] WIN_BYTES  = 32'h14;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_FLUSH    = 2;
  localparam int CTRL_CLR_DONE = 3;

  // STATUS read bits
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_EMPTY     = 3;
  localparam int STAT_FULL      = 4;
  localparam int STAT_OVF       = 5;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fsm_e;

endpackage

// File: rtl/lfsr_ctrl_fifo.sv
// Synchronous output FIFO with first-word-fall-through head.
// Ports:
//   clk_i, arst_ni       clock, async active-low reset (clears contents)
//   push_i, wdata_i      write request and data
//   pop_i                consume the head word
//   flush_i              empty the FIFO; overrides a push in the same cycle
//   head_o               current head word (valid when !empty_o)
//   full_o, empty_o      occupancy flags
//   level_o              number of stored words (0..DEPTH)
module lfsr_ctrl_fifo #(
  parameter int DEPTH_POW = 3,
  parameter int W         = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [W-1:0]         wdata_i,
  output logic [W-1:0]         head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_POW:0]   level_o
);

  localparam int DEPTH = 2 ** DEPTH_POW;
  localparam logic [DEPTH_POW:0] FULL_LVL = (DEPTH_POW + 1)'(DEPTH);

  logic [W-1:0]         r_mem [DEPTH];
  logic [DEPTH_POW-1:0] r_wptr;
  logic [DEPTH_POW-1:0] r_rptr;
  logic [DEPTH_POW:0]   r_level;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full_o  = (r_level == FULL_LVL);
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign head_o  = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so push on full is allowed with pop.
  assign w_do_pop  = pop_i && !empty_o && !flush_i;
  assign w_do_push = push_i && !flush_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Bus-mapped run controller for a single-step combinational LFSR datapath.
// Holds the LFSR state, steps it a programmed number of times through the
// external datapath and queues every generated word for the host.
// Ports:
//   clk_i, arst_ni                 clock, async active-low reset
//   bus_req_i, bus_we_i            bus request / write enable
//   bus_addr_bi, bus_be_bi         byte address, byte enables (ignored)
//   bus_wdata_bi                   write data
//   bus_ack_o                      request hits the register window
//   bus_resp_o, bus_rdata_bo       read response and data, 1 cycle later
//   lfsr_state_bo, lfsr_next_bi    state to datapath, next state back
//   busy_o, irq_o                  run in progress, level copy of DONE
//   dbg_state_o                    run FSM state
//
// Bus handshake: bus_ack_o is combinational (req AND address in window) and
// every acked access completes in that cycle; an acked read returns
// bus_resp_o=1 with its data exactly one cycle later, with data 0 otherwise.
module lfsr_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h00000010,
  parameter int          FIFO_DEPTH_POW = 3,
  parameter int          CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic [31:0] lfsr_state_bo,
  input  logic [31:0] lfsr_next_bi,
  output logic        busy_o,
  output logic        irq_o,
  output logic [1:0]  dbg_state_o
);

  fsm_e                  r_fsm;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_ovf;
  logic [31:0]           r_state;
  logic [31:0]           r_seed;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_remaining;
  logic                  r_resp;
  logic [31:0]           r_rdata;

  logic [31:0]           w_off;
  logic                  w_wr, w_rd, w_ctrl_wr;
  logic                  w_start, w_abort, w_flush, w_clr_done;
  logic                  w_data_rd, w_pop, w_push, w_room;
  logic                  w_full, w_empty;
  logic [FIFO_DEPTH_POW:0] w_level;
  logic [31:0]           w_head;
  logic [31:0]           w_status;
  logic [31:0]           w_rd_mux;
  logic                  w_unused_be;

  assign w_unused_be = ^bus_be_bi;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign w_off      = bus_addr_bi - BASE_ADDR;
  assign bus_ack_o  = bus_req_i && (w_off < WIN_BYTES);
  assign w_wr       = bus_ack_o && bus_we_i;
  assign w_rd       = bus_ack_o && !bus_we_i;
  assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL);
  assign w_start    = w_ctrl_wr && bus_wdata_bi[CTRL_START];
  assign w_abort    = w_ctrl_wr && bus_wdata_bi[CTRL_ABORT];
  assign w_flush    = w_ctrl_wr && bus_wdata_bi[CTRL_FLUSH];
  assign w_clr_done = w_ctrl_wr && bus_wdata_bi[CTRL_CLR_DONE];
  assign w_data_rd  = w_rd && (w_off == OFF_DATA);
  assign w_pop      = w_data_rd && !w_empty;
  assign w_room     = !w_full || w_pop;
  // ABORT takes the FSM to IDLE without a final push.
  assign w_push     = (r_fsm == S_RUN) && w_room && !w_abort;

  lfsr_ctrl_fifo #(.DEPTH_POW(FIFO_DEPTH_POW), .W(32)) u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .wdata_i (lfsr_next_bi),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]  = r_busy;
    w_status[STAT_DONE]  = r_done;
    w_status[STAT_ERR]   = r_err;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_LEVEL_LSB +: FIFO_DEPTH_POW + 1] = w_level;
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_STATUS: w_rd_mux = w_status;
      OFF_SEED:   w_rd_mux = r_seed;
      OFF_COUNT:  w_rd_mux = {{(32 - CNT_W){1'b0}}, r_count};
      OFF_DATA:   w_rd_mux = w_empty ? '0 : w_head;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_seed  <= 32'h1;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rd_mux : '0;
      if (!r_busy && w_wr && (w_off == OFF_SEED))  r_seed  <= bus_wdata_bi;
      if (!r_busy && w_wr && (w_off == OFF_COUNT)) r_count <= bus_wdata_bi[CNT_W-1:0];
      if (w_data_rd && w_empty) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_fsm       <= S_IDLE;
      r_busy      <= 1'b0;
      r_state     <= 32'h1;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_clr_done) r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (w_start && !w_abort) begin
            if (r_seed == '0) begin
              r_err <= 1'b1;
            end else if (r_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= r_seed;
              r_remaining <= r_count;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
              r_fsm       <= S_RUN;
              r_busy      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_fsm  <= S_IDLE;
            r_busy <= 1'b0;
          end else if (w_room) begin
            // State advances even if a simultaneous FLUSH discards the word.
            r_state     <= lfsr_next_bi;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_fsm  <= S_IDLE;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end else begin
            r_fsm <= S_STALL;
          end
        end
        S_STALL: begin
          if (w_abort) begin
            r_fsm  <= S_IDLE;
            r_busy <= 1'b0;
          end else if (w_room) begin
            r_fsm <= S_RUN;
          end
        end
        default: begin
          r_fsm  <= S_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus_resp_o    = r_resp;
  assign bus_rdata_bo  = r_rdata;
  assign lfsr_state_bo = r_state;
  assign busy_o        = r_busy;
  assign irq_o         = r_done;
  assign dbg_state_o   = r_fsm;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl with a stub datapath (next = state + 1).
// The reference model tracks the host-visible picture: a queue of words in
// the FIFO, words still owed by the run, and the DONE/ERR/OVF flags.
module tb_lfsr_ctrl;

  localparam logic [31:0] BASE = 32'h10;
  localparam logic [31:0] R_CTRL = 32'h00, R_STATUS = 32'h04, R_SEED = 32'h08;
  localparam logic [31:0] R_COUNT = 32'h0C, R_DATA = 32'h10;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        ack, resp, busy, irq;
  logic [31:0] rdata, lstate, lnext;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;
  assign lnext = lstate + 32'd1;

  lfsr_ctrl dut (
    .clk_i(clk), .arst_ni(arst_ni), .bus_req_i(req), .bus_we_i(we),
    .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
    .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata),
    .lfsr_state_bo(lstate), .lfsr_next_bi(lnext),
    .busy_o(busy), .irq_o(irq), .dbg_state_o(dbg_state)
  );

  // scoreboard / model
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_lfsr = 32'h1, m_seed = 32'h1, m_count = 32'h0;
  int          m_pending = 0;
  bit          m_done = 0, m_err = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Words owed by the run enter the FIFO while it has space.
  task automatic settle();
    while (exp_q.size() < 8 && m_pending > 0) begin
      m_lfsr = m_lfsr + 1;
      exp_q.push_back(m_lfsr);
      m_pending--;
      if (m_pending == 0) m_done = 1;
    end
  endtask

  function automatic logic [31:0] exp_status();
    int lvl = exp_q.size();
    return 32'((m_pending > 0 ? 1 : 0) + (m_done ? 2 : 0) + (m_err ? 4 : 0) +
               (lvl == 0 ? 8 : 0) + (lvl == 8 ? 16 : 0) + (m_ovf ? 32 : 0) + lvl * 256);
  endfunction

  // driver tasks
  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk); req = 1; we = 1; addr = BASE + off; wdata = data;
    @(negedge clk); req = 0; we = 0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    @(negedge clk); req = 1; we = 0; addr = BASE + off;
    @(negedge clk); req = 0;
    chk("read_resp", 32'(resp), 32'd1);
    d = rdata;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus_write(off, data);
    case (off)
      R_SEED:  if (m_pending == 0) m_seed = data;
      R_COUNT: if (m_pending == 0) m_count = data & 32'hFFFF;
      R_CTRL: begin
        if (data[3]) m_done = 0;
        if (data[2]) exp_q.delete();
        if (!data[1] && data[0] && m_pending == 0) begin
          if (m_seed == 0) m_err = 1;
          else if (m_count == 0) m_done = 1;
          else begin
            m_lfsr = m_seed; m_pending = int'(m_count); m_done = 0; m_err = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic read_data_chk(input string tag);
    logic [31:0] d, e;
    bus_read(R_DATA, d);
    if (exp_q.size() == 0) begin e = 0; m_ovf = 1; end
    else e = exp_q.pop_front();
    chk(tag, d, e);
    settle();
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_read(R_STATUS, d);
    chk(tag, d, exp_status());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) read_data_chk(tag);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, s;
    int cnt, k, c;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_state", lstate, 32'h1);
    arst_ni = 1;
    chk_status("rst_status");
    bus_read(R_SEED, d);  chk("rst_seed", d, 32'h1);
    bus_read(R_COUNT, d); chk("rst_count", d, 0);

    // SEED=5 COUNT=3: busy for 3 cycles, words 6,7,8
    wr(R_SEED, 5); wr(R_COUNT, 3); wr(R_CTRL, 1);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge clk); end
    chk("busy_len_3", 32'(cnt), 3);
    settle();
    chk("irq_after_3", 32'(irq), 32'(m_done));
    chk("state_after_3", lstate, m_lfsr);
    chk_status("status_after_3");
    drain("data_run3");
    chk_status("status_empty_3");

    wr(R_CTRL, 32'h8);
    chk("irq_clr_done", 32'(irq), 0);

    // COUNT=12 without reads: stall with a full FIFO
    wr(R_COUNT, 32'hABCD_000C);
    bus_read(R_COUNT, d); chk("count_width", d, 32'hC);
    wr(R_CTRL, 1);
    repeat (20) @(negedge clk);
    settle();
    chk_status("status_stall");
    chk("state_stall", lstate, m_lfsr);
    wr(R_SEED, 32'h99);
    bus_read(R_SEED, d); chk("seed_busy_ignored", d, m_seed);
    wr(R_CTRL, 1);
    for (int i = 0; i < 8; i++) read_data_chk("data_stall_drain");
    wait_idle(50);
    chk_status("status_after_stall");
    drain("data_stall_tail");

    // SEED=0 error, COUNT=0 immediate done
    wr(R_SEED, 0); wr(R_CTRL, 1);
    chk("busy_seed0", 32'(busy), 0);
    chk_status("status_err");
    wr(R_SEED, 9); wr(R_COUNT, 0); wr(R_CTRL, 1);
    chk("irq_count0", 32'(irq), 32'(m_done));
    chk("busy_count0", 32'(busy), 0);
    chk_status("status_count0");

    // empty DATA read
    read_data_chk("data_empty");
    chk_status("status_ovf");

    // ABORT after K pushes
    for (int it = 0; it < 3; it++) begin
      s = (it == 0) ? 32'd5 : $urandom_range(1, 32'h00FF_FFFF);
      k = (it == 0) ? 2 : $urandom_range(1, 7);
      wr(R_SEED, s); wr(R_COUNT, 32'(k + 1 + $urandom_range(0, 3))); wr(R_CTRL, 1);
      repeat (k - 1) @(negedge clk);
      bus_write(R_CTRL, 32'h2);
      for (int j = 0; j < k; j++) begin m_lfsr = m_lfsr + 1; exp_q.push_back(m_lfsr); end
      m_pending = 0;
      chk("busy_abort", 32'(busy), 0);
      chk("irq_abort", 32'(irq), 0);
      chk("state_abort", lstate, s + 32'(k));
      chk_status("status_abort");
      drain("data_abort");
    end

    // FLUSH while stalled: FIFO emptied, run supplies the rest
    wr(R_SEED, 5); wr(R_COUNT, 12); wr(R_CTRL, 1);
    repeat (20) @(negedge clk);
    settle();
    wr(R_CTRL, 32'h4);
    chk("busy_after_flush", 32'(busy), 1);
    settle();
    wait_idle(50);
    chk_status("status_flush_stall");
    drain("data_flush_stall");

    // FLUSH colliding with a push: only the final word survives
    s = $urandom_range(1, 32'h00FF_FFFF);
    wr(R_SEED, s); wr(R_COUNT, 3); wr(R_CTRL, 1);
    bus_write(R_CTRL, 32'h4);
    m_lfsr = m_lfsr + 2; m_pending -= 2; exp_q.delete();
    settle();
    wait_idle(50);
    chk_status("status_flush_push");
    drain("data_flush_push");

    // random runs that fit in the FIFO
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(1, 32'h7FFF_FFFF);
      c = $urandom_range(1, 8);
      wr(R_SEED, s); wr(R_COUNT, 32'(c)); wr(R_CTRL, 1);
      cnt = 0;
      while (busy && cnt < 100) begin cnt++; @(negedge clk); end
      chk("busy_len_rand", 32'(cnt), 32'(c));
      settle();
      chk("irq_rand", 32'(irq), 1);
      chk("state_rand", lstate, m_lfsr);
      chk_status("status_rand");
      drain("data_rand");
    end

    // window decode
    @(negedge clk); req = 1; we = 0; addr = BASE + 32'h14; #1;
    chk("ack_oob_hi", 32'(ack), 0);
    @(negedge clk); req = 0; chk("resp_oob_hi", 32'(resp), 0);
    @(negedge clk); req = 1; we = 0; addr = BASE - 32'h4; #1;
    chk("ack_oob_lo", 32'(ack), 0);
    @(negedge clk); req = 0; chk("resp_oob_lo", 32'(resp), 0);
    @(negedge clk); req = 1; we = 0; addr = BASE + R_STATUS; #1;
    chk("ack_in_win", 32'(ack), 1);
    @(negedge clk); req = 0;
    bus_write(32'h2, 32'hFFFF_FFFF);
    chk("busy_unmapped_wr", 32'(busy), 0);
    bus_read(32'h2, d);   chk("rd_unmapped", d, 0);
    bus_read(R_CTRL, d);  chk("rd_ctrl", d, 0);

    // reset mid-run
    wr(R_SEED, 5); wr(R_COUNT, 12); wr(R_CTRL, 1);
    repeat (4) @(negedge clk);
    #2 arst_ni = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_state", lstate, 32'h1);
    chk("arst_resp", 32'(resp), 0);
    chk("arst_rdata", rdata, 0);
    exp_q.delete(); m_pending = 0; m_done = 0; m_err = 0; m_ovf = 0;
    m_lfsr = 1; m_seed = 1; m_count = 0;
    @(negedge clk); arst_ni = 1;
    chk_status("arst_status");
    bus_read(R_SEED, d); chk("arst_seed", d, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
